// File: rtl/reset_sequencer.sv
// reset_sequencer: releases NUM_DOMAINS reset domains in order once the PLL lock is stable.
// Define RST_SEQ_WDOG_EN to add the DOMAIN_READY timeout watchdog and the sticky seq_err flag.
module reset_sequencer #(
  parameter int NUM_DOMAINS = 4,
  parameter int STAGE_DELAY = 1000,
  parameter int LOCK_FILTER = 16,
  parameter int TIMEOUT     = 65535
) (
  input  logic                   clk,
  input  logic                   fabric_reset_n,
  input  logic                   pll_lock,
  input  logic                   sw_rst_req,
  input  logic [NUM_DOMAINS-1:0] domain_ready,
  output logic [NUM_DOMAINS-1:0] domain_rst_n,
  output logic                   seq_done,
  output logic                   seq_err,
  output logic [2:0]             state
);
  localparam int MAX_AB = STAGE_DELAY > LOCK_FILTER ? STAGE_DELAY : LOCK_FILTER;
  localparam int CW = $clog2((MAX_AB > TIMEOUT ? MAX_AB : TIMEOUT) + 1);
  localparam int KW = $clog2(NUM_DOMAINS);
  localparam logic [CW-1:0] DLY_MAX  = CW'(STAGE_DELAY);
  localparam logic [CW-1:0] DLY_LAST = CW'(STAGE_DELAY - 1);
  localparam logic [CW-1:0] FLT_LAST = CW'(LOCK_FILTER - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(NUM_DOMAINS - 1);

  typedef enum logic [2:0] {IDLE, LOCK_WAIT, RELEASE, WAIT, RUN, HOLD, ERROR} state_t;

  state_t        st;
  logic [CW-1:0] flt, dly;
  logic [KW-1:0] k;
  logic          lost, tmo;

  assign state = st;
  assign lost  = !pll_lock && (st == RELEASE || st == WAIT || st == RUN || st == HOLD);

`ifdef RST_SEQ_WDOG_EN
  localparam logic [CW-1:0] TO_MAX  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] wcnt;
  assign tmo = st == WAIT && wcnt >= TO_LAST && !domain_ready[k];
  always_ff @(posedge clk or negedge fabric_reset_n)
    if (!fabric_reset_n) begin
      wcnt    <= '0;
      seq_err <= 1'b0;
    end else begin
      wcnt    <= st == RELEASE ? '0 : (st == WAIT && wcnt != TO_MAX) ? wcnt + 1'b1 : wcnt;
      seq_err <= sw_rst_req ? 1'b0 : (tmo && !lost) ? 1'b1 : seq_err;
    end
`else
  assign tmo     = 1'b0;
  assign seq_err = 1'b0;
`endif

  // Priority: async reset, lock loss, software request, then per-state progress.
  always_ff @(posedge clk or negedge fabric_reset_n)
    if (!fabric_reset_n) begin
      st           <= IDLE;
      flt          <= '0;
      dly          <= '0;
      k            <= '0;
      domain_rst_n <= '0;
      seq_done     <= 1'b0;
    end else if (lost) begin
      st           <= LOCK_WAIT;
      flt          <= '0;
      domain_rst_n <= '0;
      seq_done     <= 1'b0;
    end else if (sw_rst_req) begin
      st           <= HOLD;
      dly          <= '0;
      domain_rst_n <= '0;
      seq_done     <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          st  <= LOCK_WAIT;
          flt <= '0;
        end
        LOCK_WAIT: begin
          flt <= pll_lock ? flt + 1'b1 : '0;
          if (pll_lock && flt >= FLT_LAST) begin
            st <= RELEASE;
            k  <= '0;
          end
        end
        RELEASE: begin
          domain_rst_n[k] <= 1'b1;
          dly             <= '0;
          st              <= WAIT;
        end
        WAIT: begin
          dly <= dly == DLY_MAX ? dly : dly + 1'b1;
          if (tmo) begin
            st           <= ERROR;
            domain_rst_n <= '0;
          end else if (dly >= DLY_LAST && domain_ready[k]) begin
            st       <= k == K_LAST ? RUN : RELEASE;
            seq_done <= k == K_LAST;
            k        <= k == K_LAST ? k : k + 1'b1;
          end
        end
        HOLD: begin
          dly <= dly == DLY_MAX ? dly : dly + 1'b1;
          if (dly >= DLY_LAST) begin
            st  <= LOCK_WAIT;
            flt <= '0;
          end
        end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed scoreboard bench; each output change is matched
// against a queued expectation carrying the edge number since reset release.
module tb_reset_sequencer;
  logic       clk = 1'b0;
  logic       fabric_reset_n, pll_lock, sw_rst_req;
  logic [3:0] domain_ready, domain_rst_n;
  logic       seq_done, seq_err;
  logic [2:0] state;
  int         total = 0, bad = 0, edge_n = 0;
  logic [5:0] prev = '0;

  typedef struct {
    int         e;
    logic [3:0] rn;
    logic       d;
    logic       er;
    logic [2:0] st;
  } ev_t;
  ev_t q[$];

  reset_sequencer #(.NUM_DOMAINS(4), .STAGE_DELAY(8), .LOCK_FILTER(4), .TIMEOUT(32)) dut (
    .clk(clk), .fabric_reset_n(fabric_reset_n), .pll_lock(pll_lock), .sw_rst_req(sw_rst_req),
    .domain_ready(domain_ready), .domain_rst_n(domain_rst_n), .seq_done(seq_done),
    .seq_err(seq_err), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge fabric_reset_n)
    if (!fabric_reset_n) edge_n <= 0;
    else edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (fabric_reset_n && {domain_rst_n, seq_done, seq_err} !== prev) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event edge=%0d got rst_n=%b done=%b err=%b state=%0d want no change",
                 edge_n, domain_rst_n, seq_done, seq_err, state);
      end else begin
        ev_t x;
        x = q.pop_front();
        if (x.e != edge_n || x.rn !== domain_rst_n || x.d !== seq_done || x.er !== seq_err || x.st !== state) begin
          bad++;
          $display("FAIL event got edge=%0d rst_n=%b done=%b err=%b state=%0d want edge=%0d rst_n=%b done=%b err=%b state=%0d",
                   edge_n, domain_rst_n, seq_done, seq_err, state, x.e, x.rn, x.d, x.er, x.st);
        end
      end
    end
    prev = {domain_rst_n, seq_done, seq_err};
  end

  task automatic exp_ev(input int e, input logic [3:0] rn, input logic d, input logic er, input logic [2:0] s);
    ev_t x;
    x.e = e; x.rn = rn; x.d = d; x.er = er; x.st = s;
    q.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  task automatic sync_to(input int e);
    while (edge_n < e - 1) @(negedge clk);
  endtask

  task automatic start_run(input logic [3:0] rdy);
    fabric_reset_n = 1'b0;
    pll_lock       = 1'b1;
    sw_rst_req     = 1'b0;
    domain_ready   = rdy;
    repeat (2) @(negedge clk);
    fabric_reset_n = 1'b1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL %s pending=%0d want 0", nm, q.size());
      q.delete();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench timeout");
  end

  initial begin
    fabric_reset_n = 1'b0;
    pll_lock       = 1'b0;
    sw_rst_req     = 1'b0;
    domain_ready   = 4'h0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {23'd0, domain_rst_n, seq_done, seq_err, state}, 32'd0);

    // Nominal sequence, then a one-cycle lock loss in RUN.
    start_run(4'hF);
    exp_ev(6, 4'b0001, 0, 0, 3);
    exp_ev(15, 4'b0011, 0, 0, 3);
    exp_ev(24, 4'b0111, 0, 0, 3);
    exp_ev(33, 4'b1111, 0, 0, 3);
    exp_ev(41, 4'b1111, 1, 0, 4);
    exp_ev(45, 4'b0000, 0, 0, 1);
    exp_ev(50, 4'b0001, 0, 0, 3);
    exp_ev(59, 4'b0011, 0, 0, 3);
    exp_ev(68, 4'b0111, 0, 0, 3);
    exp_ev(77, 4'b1111, 0, 0, 3);
    exp_ev(85, 4'b1111, 1, 0, 4);
    sync_to(2);
    chk("idle_to_lock_wait", {29'd0, state}, 32'd1);
    sync_to(6);
    chk("release_state", {29'd0, state}, 32'd2);
    sync_to(45); pll_lock = 1'b0;
    sync_to(46); pll_lock = 1'b1;
    drain("nominal_and_lock_loss");

    // Lock filter restarts on each low sample; domain 1 ready stalls WAIT.
    start_run(4'hF);
    exp_ev(12, 4'b0001, 0, 0, 3);
    exp_ev(21, 4'b0011, 0, 0, 3);
    exp_ev(43, 4'b0111, 0, 0, 3);
    exp_ev(52, 4'b1111, 0, 0, 3);
    exp_ev(60, 4'b1111, 1, 0, 4);
    sync_to(4); pll_lock = 1'b0;
    sync_to(5); pll_lock = 1'b1;
    sync_to(7); pll_lock = 1'b0;
    sync_to(8); pll_lock = 1'b1;
    sync_to(22); domain_ready = 4'b1101;
    sync_to(42);
    chk("stall_state", {29'd0, state}, 32'd3);
    chk("stall_rst_n", {28'd0, domain_rst_n}, 32'h3);
    chk("stall_no_err", {31'd0, seq_err}, 32'd0);
    domain_ready = 4'hF;
    drain("filter_and_stall");

    // Asynchronous reset in the middle of WAIT.
    start_run(4'hF);
    exp_ev(6, 4'b0001, 0, 0, 3);
    sync_to(10);
    chk("pre_async_rst_n", {28'd0, domain_rst_n}, 32'h1);
    #2 fabric_reset_n = 1'b0;
    #1 chk("async_reset", {23'd0, domain_rst_n, seq_done, seq_err, state}, 32'd0);
    drain("async_reset_events");

    // Lock loss beats a simultaneous software request; lone request goes to HOLD.
    start_run(4'hF);
    exp_ev(6, 4'b0001, 0, 0, 3);
    exp_ev(10, 4'b0000, 0, 0, 1);
    exp_ev(15, 4'b0001, 0, 0, 3);
    exp_ev(20, 4'b0000, 0, 0, 5);
    exp_ev(33, 4'b0001, 0, 0, 3);
    sync_to(10); sw_rst_req = 1'b1; pll_lock = 1'b0;
    sync_to(11); sw_rst_req = 1'b0; pll_lock = 1'b1;
    sync_to(20); sw_rst_req = 1'b1;
    sync_to(21); sw_rst_req = 1'b0;
    sync_to(26);
    chk("hold_state", {29'd0, state}, 32'd5);
    sync_to(31);
    chk("hold_exit_lock_wait", {29'd0, state}, 32'd1);
    drain("sw_and_lock_loss");

`ifdef RST_SEQ_WDOG_EN
    // Domain 2 never ready: watchdog trips, lock loss ignored, software request recovers.
    start_run(4'b1011);
    exp_ev(6, 4'b0001, 0, 0, 3);
    exp_ev(15, 4'b0011, 0, 0, 3);
    exp_ev(24, 4'b0111, 0, 0, 3);
    exp_ev(56, 4'b0000, 0, 1, 6);
    exp_ev(65, 4'b0000, 0, 0, 5);
    exp_ev(78, 4'b0001, 0, 0, 3);
    exp_ev(87, 4'b0011, 0, 0, 3);
    exp_ev(96, 4'b0111, 0, 0, 3);
    exp_ev(105, 4'b1111, 0, 0, 3);
    exp_ev(113, 4'b1111, 1, 0, 4);
    sync_to(60); pll_lock = 1'b0;
    sync_to(61); pll_lock = 1'b1;
    sync_to(62);
    chk("error_ignores_lock_loss", {29'd0, state}, 32'd6);
    sync_to(65); sw_rst_req = 1'b1; domain_ready = 4'hF;
    sync_to(66); sw_rst_req = 1'b0;
    drain("watchdog");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
